// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch/timer mode controller: 4-digit BCD time, internal tick prescaler, 4-state FSM
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        start,
    input  logic        clr,
    input  logic [15:0] preset,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic [1:0]  state
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     time_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      mode_q, mode_d;
    logic [15:0]     init_val;
    logic [15:0]     step_val;

    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    // Ripple carry/borrow across digits; callers never step past 9999 or 0000.
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic down);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (down) begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] terminal(input logic down);
        return down ? 16'h0000 : 16'h9999;
    endfunction

    always_comb begin
        case (mode)
            2'd0:    init_val = 16'h0000;
            2'd2:    init_val = 16'h9999;
            default: init_val = sanitize(preset);
        endcase
    end

    assign step_val = bcd_step(time_bcd, mode_q[1]);

    always_comb begin
        state_d = state_q;
        time_d  = time_bcd;
        presc_d = presc_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                time_d = init_val;
                if (!clr && start) begin
                    mode_d  = mode;
                    presc_d = '0;
                    state_d = (init_val == terminal(mode[1])) ? DONE : RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = IDLE;
                    time_d  = init_val;
                end else if (start) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    time_d  = step_val;
                    if (step_val == terminal(mode_q[1]))
                        state_d = DONE;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PAUSE: begin
                if (clr) begin
                    state_d = IDLE;
                    time_d  = init_val;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clr) begin
                    state_d = IDLE;
                    time_d  = init_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            time_bcd <= 16'h0000;
            presc_q  <= '0;
            mode_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            time_bcd <= time_d;
            presc_q  <= presc_d;
            mode_q   <= mode_d;
        end
    end

    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl with TICK_DIV=4
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .start    (start),
        .clr      (clr),
        .preset   (preset),
        .time_bcd (time_bcd),
        .running  (running),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the pulse is sampled on the next posedge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        checks++;
        if (time_bcd !== 16'h0000 || state !== 2'd0 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got time=%h state=%0d run=%b done=%b, expected 0000/0/0/0",
                     time_bcd, state, running, done);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_up_carry();
        mode = 2'd0;
        @(negedge clk);
        pulse_start();
        repeat (40) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0010 || running !== 1'b1) begin
            errors++;
            $display("FAIL up_carry_10: got time=%h run=%b, expected 0010/1", time_bcd, running);
        end
        repeat (360) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0100) begin
            errors++;
            $display("FAIL up_carry_100: got %h expected 0100", time_bcd);
        end
        pulse_clr();
    endtask

    task automatic test_down_full();
        mode = 2'd2;
        @(negedge clk);
        checks++;
        if (time_bcd !== 16'h9999) begin
            errors++;
            $display("FAIL down_init: got %h expected 9999", time_bcd);
        end
        pulse_start();
        repeat (4) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h9998) begin
            errors++;
            $display("FAIL down_first_tick: got %h expected 9998", time_bcd);
        end
        repeat (4 * 9998) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0000 || done !== 1'b1 || state !== 2'd3 || running !== 1'b0) begin
            errors++;
            $display("FAIL down_done: got time=%h done=%b state=%0d run=%b, expected 0000/1/3/0",
                     time_bcd, done, state, running);
        end
        pulse_start();
        repeat (20) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0000 || state !== 2'd3) begin
            errors++;
            $display("FAIL down_hold: got time=%h state=%0d, expected 0000/3", time_bcd, state);
        end
        pulse_clr();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL done_clr: got state=%0d expected 0", state);
        end
    endtask

    task automatic test_pause();
        mode = 2'd0;
        @(negedge clk);
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        repeat (100) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0010 || state !== 2'd2) begin
            errors++;
            $display("FAIL pause_hold: got time=%h state=%0d, expected 0010/2", time_bcd, state);
        end
        pulse_start();
        repeat (2) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0010 || state !== 2'd1) begin
            errors++;
            $display("FAIL resume_early: got time=%h state=%0d, expected 0010/1", time_bcd, state);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0011) begin
            errors++;
            $display("FAIL resume_tick: got %h expected 0011", time_bcd);
        end
        pulse_clr();
    endtask

    task automatic test_down_preset();
        mode   = 2'd3;
        preset = 16'h0105;
        @(negedge clk);
        pulse_start();
        repeat (4) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0104) begin
            errors++;
            $display("FAIL preset_down_1: got %h expected 0104", time_bcd);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0100) begin
            errors++;
            $display("FAIL preset_down_5: got %h expected 0100", time_bcd);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0099) begin
            errors++;
            $display("FAIL preset_borrow: got %h expected 0099", time_bcd);
        end
        pulse_clr();
        preset = 16'h0000;
        @(negedge clk);
        pulse_start();
        checks++;
        if (state !== 2'd3 || done !== 1'b1 || time_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL preset_zero_done: got state=%0d done=%b time=%h, expected 3/1/0000",
                     state, done, time_bcd);
        end
        pulse_clr();
        mode   = 2'd1;
        preset = 16'h9999;
        @(negedge clk);
        pulse_start();
        checks++;
        if (state !== 2'd3 || time_bcd !== 16'h9999) begin
            errors++;
            $display("FAIL up_preset_terminal: got state=%0d time=%h, expected 3/9999", state, time_bcd);
        end
        pulse_clr();
    endtask

    task automatic test_clr_and_reset();
        mode   = 2'd1;
        preset = 16'h0042;
        @(negedge clk);
        pulse_start();
        repeat (8) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h0044) begin
            errors++;
            $display("FAIL clr_pre_run: got %h expected 0044", time_bcd);
        end
        start = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || time_bcd !== 16'h0042) begin
            errors++;
            $display("FAIL clr_over_start: got state=%0d time=%h, expected 0/0042", state, time_bcd);
        end
        pulse_start();
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (time_bcd !== 16'h0000 || state !== 2'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_run: got time=%h state=%0d run=%b, expected 0000/0/0",
                     time_bcd, state, running);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sanitise();
        mode   = 2'd1;
        preset = 16'h1A3F;
        @(negedge clk);
        checks++;
        if (time_bcd !== 16'h1939) begin
            errors++;
            $display("FAIL sanitise_idle: got %h expected 1939", time_bcd);
        end
        pulse_start();
        repeat (4) @(negedge clk);
        checks++;
        if (time_bcd !== 16'h1940) begin
            errors++;
            $display("FAIL sanitise_tick: got %h expected 1940", time_bcd);
        end
        pulse_clr();
    endtask

    initial begin
        test_reset();
        test_up_carry();
        test_down_full();
        test_pause();
        test_down_preset();
        test_clr_and_reset();
        test_sanitise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
